// File: rtl/tt_mux_pkg.sv
// Shared types and bundle layout for the muxperiment controller and its output selector.
package tt_mux_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StRsthold,
        StRun
    } mux_state_e;

    // Bundle widths toward and from a project wrapper.
    localparam int unsigned IW_W = 18;
    localparam int unsigned OW_W = 24;

    // iw field offsets.
    localparam int unsigned IW_CLK  = 0;
    localparam int unsigned IW_RSTN = 1;
    localparam int unsigned IW_UI   = 2;
    localparam int unsigned IW_UIO  = 10;

    // ow field offsets.
    localparam int unsigned OW_UO  = 0;
    localparam int unsigned OW_UIO = 8;
    localparam int unsigned OW_OE  = 16;

endpackage

// File: rtl/tt_mux_ow_sel.sv
// Registered NUM_PROJ:1 selector for the 24-bit wrapper output bundles.
// The output reads zero whenever en is low, and the register only captures while en was high,
// so a freshly enabled project never shows a stale slice from the previous one.
module tt_mux_ow_sel
    import tt_mux_pkg::*;
#(
    parameter int unsigned NUM_PROJ = 8,
    parameter int unsigned AW       = $clog2(NUM_PROJ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [AW-1:0]            idx,
    input  logic [NUM_PROJ*OW_W-1:0] ow_all,
    output logic [OW_W-1:0]          ow
);

    logic [OW_W-1:0] ow_arr [NUM_PROJ];
    logic [OW_W-1:0] ow_q;

    for (genvar k = 0; k < NUM_PROJ; k++) begin : g_split
        assign ow_arr[k] = ow_all[k*OW_W +: OW_W];
    end

    // Capture the selected slice, zero while the project is not live.
    always_ff @(posedge clk) begin
        if (rst) begin
            ow_q <= '0;
        end else begin
            ow_q <= en ? ow_arr[idx] : '0;
        end
    end

    assign ow = en ? ow_q : '0;

endmodule

// File: rtl/tt_mux_ctrl.sv
// Controller side of the muxperiment project-wrapper bus.
// Sequences project switches through drain, reset-hold and run, and muxes the live
// project's outputs back to the pads.
// Optional: define TT_MUX_OE_GUARD_EN to hold uio_oe low during reset-hold and the
// first two run cycles.
module tt_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int unsigned NUM_PROJ     = 8,
    parameter int unsigned AW           = $clog2(NUM_PROJ),
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel_valid,
    output logic                     sel_ready,
    input  logic                     sel_off,
    input  logic [AW-1:0]            sel_addr,
    input  logic                     user_rst_n,
    input  logic [7:0]               ui_in,
    input  logic [7:0]               uio_in,
    input  logic [NUM_PROJ*OW_W-1:0] ow_all,
    output logic [NUM_PROJ-1:0]      ena,
    output logic [IW_W-1:0]          iw,
    output logic [7:0]               uo_out,
    output logic [7:0]               uio_out,
    output logic [7:0]               uio_oe,
    output logic                     active,
    output logic [AW-1:0]            cur_addr
);

    localparam int unsigned CntW = 16;

    mux_state_e          state_q;
    logic [AW-1:0]       addr_q;
    logic [AW-1:0]       cur_addr_q;
    logic                off_q;
    logic [CntW-1:0]     cnt_q;
    logic [NUM_PROJ-1:0] ena_q;
    logic                pclk_q;
    logic                prst_n_q;
    logic                ready_q;
    logic                active_q;
`ifdef TT_MUX_OE_GUARD_EN
    logic [1:0]          run_cnt_q;
`endif

    logic                addr_ok;
    logic                live;
    logic [15:0]         pad_q;
    logic [OW_W-1:0]     ow_sel;

    assign addr_ok = 32'(addr_q) < NUM_PROJ;
    assign live    = (state_q == StRsthold) || (state_q == StRun);

    // Switch sequencer; ena is always cleared before cur_addr can move.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cur_addr_q <= '0;
            off_q      <= 1'b0;
            cnt_q      <= '0;
            ena_q      <= '0;
            pclk_q     <= 1'b0;
            prst_n_q   <= 1'b0;
            ready_q    <= 1'b1;
            active_q   <= 1'b0;
`ifdef TT_MUX_OE_GUARD_EN
            run_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    // A deselect request while idle is accepted as a no-op.
                    if (sel_valid && !sel_off) begin
                        state_q <= StDrain;
                        addr_q  <= sel_addr;
                        off_q   <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                StDrain: begin
                    if (cnt_q == CntW'(DRAIN_CYCLES - 1)) begin
                        cnt_q <= '0;
                        if (off_q || !addr_ok) begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                        end else begin
                            state_q    <= StRsthold;
                            ena_q      <= {{(NUM_PROJ-1){1'b0}}, 1'b1} << addr_q;
                            cur_addr_q <= addr_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRsthold: begin
                    pclk_q <= ~pclk_q;
                    // Two clk per project clock period; leave on a project clock fall.
                    if (cnt_q == CntW'(2 * RST_CYCLES - 1)) begin
                        state_q   <= StRun;
                        cnt_q     <= '0;
                        prst_n_q  <= user_rst_n;
                        active_q  <= 1'b1;
                        ready_q   <= 1'b1;
`ifdef TT_MUX_OE_GUARD_EN
                        run_cnt_q <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (sel_valid) begin
                        state_q  <= StDrain;
                        addr_q   <= sel_addr;
                        off_q    <= sel_off;
                        cnt_q    <= '0;
                        ena_q    <= '0;
                        pclk_q   <= 1'b0;
                        prst_n_q <= 1'b0;
                        active_q <= 1'b0;
                        ready_q  <= 1'b0;
                    end else begin
                        pclk_q   <= ~pclk_q;
                        prst_n_q <= user_rst_n;
`ifdef TT_MUX_OE_GUARD_EN
                        if (run_cnt_q != 2'd2) begin
                            run_cnt_q <= run_cnt_q + 2'd1;
                        end
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Pad inputs toward the project, one clk behind and zero unless a project is live.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_q <= '0;
        end else begin
            pad_q <= live ? {uio_in, ui_in} : '0;
        end
    end

    // Assemble the iw bundle.
    always_comb begin
        iw          = '0;
        iw[IW_CLK]  = pclk_q;
        iw[IW_RSTN] = prst_n_q;
        if (live) begin
            iw[IW_UI +: 8]  = pad_q[7:0];
            iw[IW_UIO +: 8] = pad_q[15:8];
        end
    end

    tt_mux_ow_sel #(
        .NUM_PROJ (NUM_PROJ),
        .AW       (AW)
    ) u_ow_sel (
        .clk    (clk),
        .rst    (rst),
        .en     (live),
        .idx    (cur_addr_q),
        .ow_all (ow_all),
        .ow     (ow_sel)
    );

    assign uo_out  = ow_sel[OW_UO +: 8];
    assign uio_out = ow_sel[OW_UIO +: 8];
`ifdef TT_MUX_OE_GUARD_EN
    assign uio_oe  = ((state_q == StRun) && (run_cnt_q == 2'd2)) ? ow_sel[OW_OE +: 8] : '0;
`else
    assign uio_oe  = ow_sel[OW_OE +: 8];
`endif

    assign ena       = ena_q;
    assign sel_ready = ready_q;
    assign active    = active_q;
    assign cur_addr  = cur_addr_q;

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Self-checking bench for tt_mux_ctrl: schedule-based reference model checked every cycle,
// plus directed literal expectations.
module tb_tt_mux_ctrl;

    localparam int NP  = 6;
    localparam int AWT = 3;
    localparam int RC  = 4;
    localparam int DC  = 2;
`ifdef TT_MUX_OE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sel_valid = 1'b0;
    logic              sel_off = 1'b0;
    logic [AWT-1:0]    sel_addr = '0;
    logic              user_rst_n = 1'b1;
    logic [7:0]        ui_in = '0;
    logic [7:0]        uio_in = '0;
    logic [NP*24-1:0]  ow_all = '0;
    logic              sel_ready;
    logic [NP-1:0]     ena;
    logic [17:0]       iw;
    logic [7:0]        uo_out, uio_out, uio_oe;
    logic              active;
    logic [AWT-1:0]    cur_addr;

    int n_tests = 0;
    int n_fail  = 0;

    tt_mux_ctrl #(
        .NUM_PROJ     (NP),
        .AW           (AWT),
        .RST_CYCLES   (RC),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .sel_off    (sel_off),
        .sel_addr   (sel_addr),
        .user_rst_n (user_rst_n),
        .ui_in      (ui_in),
        .uio_in     (uio_in),
        .ow_all     (ow_all),
        .ena        (ena),
        .iw         (iw),
        .uo_out     (uo_out),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .active     (active),
        .cur_addr   (cur_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request lays out a schedule of phases that then plays out cycle by cycle.
    typedef enum int {PIdle, PDrain, PHold, PRun} ph_t;
    ph_t           m_q[$];
    ph_t           m_ph, m_tail, prev_ph;
    int            m_tgt, m_cur, m_n, m_runj;
    bit            m_valid = 1'b0;
    bit            live, was_live, ready_m;
    logic [15:0]   e_data;
    logic [23:0]   e_ow;
    logic          e_rstn;
    logic [NP-1:0] one = 1;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_ph = PIdle; m_tail = PIdle;
                m_cur = 0; m_tgt = 0; m_n = 0; m_runj = 0;
                e_data = '0; e_ow = '0; e_rstn = 1'b0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                ready_m  = (m_ph == PIdle) || (m_ph == PRun);
                was_live = (m_ph == PHold) || (m_ph == PRun);
                if (sel_valid && ready_m && !(m_ph == PIdle && sel_off)) begin
                    m_q.delete();
                    for (int i = 0; i < DC; i++) m_q.push_back(PDrain);
                    if (!sel_off && int'(sel_addr) < NP) begin
                        for (int i = 0; i < 2 * RC; i++) m_q.push_back(PHold);
                        m_tail = PRun;
                        m_tgt  = int'(sel_addr);
                    end else begin
                        m_tail = PIdle;
                    end
                end
                prev_ph = m_ph;
                m_ph = (m_q.size() > 0) ? m_q.pop_front() : m_tail;
                if (m_ph == PHold && prev_ph != PHold) m_cur = m_tgt;
                live   = (m_ph == PHold) || (m_ph == PRun);
                m_n    = (live && was_live) ? m_n + 1 : 0;
                m_runj = (m_ph == PRun && prev_ph == PRun) ? m_runj + 1 : 0;
                e_data = (live && was_live) ? {uio_in, ui_in} : 16'h0;
                e_ow   = (live && was_live) ? ow_all[24*m_cur +: 24] : 24'h0;
                e_rstn = (m_ph == PRun) ? user_rst_n : 1'b0;
            end
            #1;
            if (m_valid) begin
                live = (m_ph == PHold) || (m_ph == PRun);
                chk("ena", 32'(ena), 32'(live ? (one << m_cur) : '0));
                chk("ena_onehot", 32'($countones(ena) <= 1), 32'd1);
                chk("sel_ready", 32'(sel_ready), 32'((m_ph == PIdle) || (m_ph == PRun)));
                chk("active", 32'(active), 32'(m_ph == PRun));
                chk("cur_addr", 32'(cur_addr), 32'(m_cur));
                chk("iw", 32'(iw), 32'({e_data, e_rstn, (live ? 1'(m_n % 2) : 1'b0)}));
                chk("uo_out", 32'(uo_out), 32'(e_ow[7:0]));
                chk("uio_out", 32'(uio_out), 32'(e_ow[15:8]));
                chk("uio_oe", 32'(uio_oe),
                    32'((Guard && !(m_ph == PRun && m_runj >= 2)) ? 8'h00 : e_ow[23:16]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic request(input logic off, input logic [AWT-1:0] addr);
        sel_valid = 1'b1; sel_off = off; sel_addr = addr;
        step();
        sel_valid = 1'b0; sel_off = 1'b0;
    endtask

    task automatic wait_active(input int budget);
        for (int i = 0; i < budget && !active; i++) step();
        chk("wait_active", 32'(active), 32'd1);
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        chk("rst_ena", 32'(ena), 32'h0);
        chk("rst_ready", 32'(sel_ready), 32'h1);
        chk("rst_iw", 32'(iw), 32'h0);
        chk("rst_active", 32'(active), 32'h0);

        // Select project 3: two drain cycles, then eight clk of reset-hold.
        request(1'b0, 3'd3);
        chk("drain1_ena", 32'(ena), 32'h0);
        chk("drain1_ready", 32'(sel_ready), 32'h0);
        step();
        chk("drain2_ena", 32'(ena), 32'h0);
        step();
        chk("hold_ena", 32'(ena), 32'h08);
        chk("hold_cur", 32'(cur_addr), 32'd3);
        for (int k = 1; k < 2 * RC; k++) begin
            step();
            chk("hold_pclk", 32'(iw[0]), 32'(k % 2));
            chk("hold_rstn", 32'(iw[1]), 32'h0);
            chk("hold_active", 32'(active), 32'h0);
        end
        step();
        chk("run_active", 32'(active), 32'h1);
        chk("run_rstn", 32'(iw[1]), 32'h1);
        chk("run_pclk", 32'(iw[0]), 32'h0);

        // Output mux and input path in RUN.
        ow_all = '1;
        ow_all[24*3 +: 24] = 24'hA55A01;
        ui_in = 8'h3C;
        user_rst_n = 1'b0;
        step();
        chk("run_rstn_low", 32'(iw[1]), 32'h0);
        chk("uo_sel", 32'(uo_out), 32'h01);
        chk("uio_sel", 32'(uio_out), 32'h5A);
        chk("oe_run1", 32'(uio_oe), Guard ? 32'h00 : 32'hA5);
        chk("ui_path", 32'(iw[9:2]), 32'h3C);
        user_rst_n = 1'b1;
        step();
        chk("oe_run2", 32'(uio_oe), 32'hA5);

        // Switch 3 -> 5.
        ow_all[24*5 +: 24] = 24'h123456;
        request(1'b0, 3'd5);
        chk("sw_drain_ena", 32'(ena), 32'h0);
        chk("sw_drain_uo", 32'(uo_out), 32'h0);
        chk("sw_drain_oe", 32'(uio_oe), 32'h0);
        step();
        chk("sw_drain2_ena", 32'(ena), 32'h0);
        step();
        chk("sw_hold_ena", 32'(ena), 32'h20);
        chk("sw_cur", 32'(cur_addr), 32'd5);
        wait_active(20);
        step();
        chk("sw_uo", 32'(uo_out), 32'h56);
        chk("sw_uio", 32'(uio_out), 32'h34);

        // Deselect from RUN.
        request(1'b1, 3'd0);
        step(); step();
        chk("off_ready", 32'(sel_ready), 32'h1);
        chk("off_ena", 32'(ena), 32'h0);
        chk("off_iw", 32'(iw), 32'h0);
        chk("off_uo", 32'(uo_out), 32'h0);

        // Out-of-range target never enables anything.
        request(1'b0, 3'd6);
        chk("oor_ready", 32'(sel_ready), 32'h0);
        step(); step();
        chk("oor_idle", 32'(sel_ready), 32'h1);
        chk("oor_ena", 32'(ena), 32'h0);
        chk("oor_cur", 32'(cur_addr), 32'd5);
        step();

        // Reset in the middle of reset-hold, then a fresh full sequence.
        request(1'b0, 3'd2);
        step(); step(); step();
        chk("mid_hold_ena", 32'(ena), 32'h04);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ena", 32'(ena), 32'h0);
        chk("mid_rst_iw", 32'(iw), 32'h0);
        chk("mid_rst_ready", 32'(sel_ready), 32'h1);
        request(1'b0, 3'd2);
        wait_active(30);
        chk("fresh_ena", 32'(ena), 32'h04);

        // uio_oe guard behaviour with all-ones wrapper outputs.
        ow_all = '1;
        request(1'b0, 3'd1);
        step(); step();
        chk("oe_hold0", 32'(uio_oe), 32'h00);
        step();
        chk("oe_hold1", 32'(uio_oe), Guard ? 32'h00 : 32'hFF);
        chk("uo_hold1", 32'(uo_out), 32'hFF);
        wait_active(20);
        chk("oe_run0", 32'(uio_oe), Guard ? 32'h00 : 32'hFF);
        step();
        chk("oe_run1b", 32'(uio_oe), Guard ? 32'h00 : 32'hFF);
        step();
        chk("oe_run2b", 32'(uio_oe), 32'hFF);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
